// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm clock blocks.
// Segment patterns are active-low, a..g at indices 0..6.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  localparam logic [0:6] SEG7_A     = 7'b0001000;
  localparam logic [0:6] SEG7_S     = 7'b0100100;
  localparam logic [0:6] SEG7_BLANK = 7'b1111111;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a level input.
// RST_VAL=1 suppresses an edge for a level already high at reset release.
module rise_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringing session controller: blinking buzzer, bounded ring time,
// limited snoozes and an active-low status digit.
module alarm_ringer
  import clock_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZES    = 3,
  localparam int RW  = $clog2(RING_SECONDS),
  localparam int SW  = $clog2(SNOOZE_SECONDS),
  localparam int SCW = $clog2(MAX_SNOOZES + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sec_tick,
  input  logic           alarm_trigger,
  input  logic           alarm_enable,
  input  logic           snooze_btn,
  input  logic           stop_btn,
  output logic           buzzer,
  output logic           ringing,
  output logic           snoozing,
  output logic [SCW-1:0] snooze_count,
  output logic [0:6]     alarm_signal
);

  localparam logic [RW-1:0]  RING_LAST   = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0]  SNOOZE_LAST = SW'(SNOOZE_SECONDS - 1);
  localparam logic [SCW-1:0] SNZ_MAX     = SCW'(MAX_SNOOZES);

  alarm_state_t   state, state_n;
  logic [RW-1:0]  ring_cnt, ring_n;
  logic [SW-1:0]  snz_cnt, snz_n;
  logic [SCW-1:0] scnt_n;
  logic           phase, phase_n;
  logic           trig_rise;

  rise_detect #(.RST_VAL(1'b1)) u_trig (
    .clk  (clk),
    .rst  (rst),
    .d    (alarm_trigger),
    .rise (trig_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ring_cnt     <= '0;
      snz_cnt      <= '0;
      phase        <= 1'b0;
      snooze_count <= '0;
    end else begin
      state        <= state_n;
      ring_cnt     <= ring_n;
      snz_cnt      <= snz_n;
      phase        <= phase_n;
      snooze_count <= scnt_n;
    end
  end

  // Priority: disable/stop, then snooze, then the one-second tick.
  always_comb begin
    state_n = state;
    ring_n  = ring_cnt;
    snz_n   = snz_cnt;
    phase_n = phase;
    scnt_n  = snooze_count;
    case (state)
      IDLE: begin
        if (trig_rise && alarm_enable) begin
          state_n = RINGING;
          ring_n  = '0;
          scnt_n  = '0;
          phase_n = 1'b1;
        end
      end
      RINGING: begin
        if (!alarm_enable || stop_btn) begin
          state_n = IDLE;
        end else if (snooze_btn && (snooze_count < SNZ_MAX)) begin
          state_n = SNOOZE;
          scnt_n  = snooze_count + SCW'(1);
          snz_n   = '0;
        end else if (sec_tick) begin
          phase_n = ~phase;
          if (ring_cnt == RING_LAST) state_n = IDLE;
          else                       ring_n  = ring_cnt + RW'(1);
        end
      end
      SNOOZE: begin
        if (!alarm_enable || stop_btn) begin
          state_n = IDLE;
        end else if (sec_tick) begin
          if (snz_cnt == SNOOZE_LAST) begin
            state_n = RINGING;
            ring_n  = '0;
            phase_n = 1'b1;
          end else begin
            snz_n = snz_cnt + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ringing  = (state == RINGING);
  assign snoozing = (state == SNOOZE);
  assign buzzer   = ringing & phase;

  always_comb begin
    alarm_signal = SEG7_BLANK;
    if (ringing && phase) alarm_signal = SEG7_A;
    else if (snoozing)    alarm_signal = SEG7_S;
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with RING=4, SNOOZE=3, MAX_SNOOZES=2,
// sec_tick every 10 clocks.
module tb_alarm_ringer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sec_tick, alarm_trigger, alarm_enable, snooze_btn, stop_btn;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_count;
  logic [0:6] alarm_signal;

  int passed = 0;
  int total  = 0;

  localparam logic [6:0] A_SEG = 7'b0001000;
  localparam logic [6:0] S_SEG = 7'b0100100;
  localparam logic [6:0] BLANK = 7'b1111111;

  alarm_ringer #(
    .RING_SECONDS   (4),
    .SNOOZE_SECONDS (3),
    .MAX_SNOOZES    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sec_tick      (sec_tick),
    .alarm_trigger (alarm_trigger),
    .alarm_enable  (alarm_enable),
    .snooze_btn    (snooze_btn),
    .stop_btn      (stop_btn),
    .buzzer        (buzzer),
    .ringing       (ringing),
    .snoozing      (snoozing),
    .snooze_count  (snooze_count),
    .alarm_signal  (alarm_signal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compact status check: {ringing, snoozing, buzzer, snooze_count, segments}
  task automatic st(input string tag, input logic r, input logic s, input logic b,
                    input logic [1:0] c, input logic [6:0] seg);
    chk(tag, {ringing, snoozing, buzzer, snooze_count, alarm_signal}, {r, s, b, c, seg});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick();
    quiet(9);
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
  endtask

  task automatic new_trigger();
    alarm_trigger = 1'b0;
    quiet(2);
    alarm_trigger = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; sec_tick = 0; alarm_trigger = 0; alarm_enable = 1;
    snooze_btn = 0; stop_btn = 0;
    quiet(2);
    st("reset_values", 0, 0, 0, 2'd0, BLANK);
    rst = 1'b0;
    quiet(3);
    st("idle_after_reset", 0, 0, 0, 2'd0, BLANK);

    // Trigger and timeout
    alarm_trigger = 1'b1;
    step();
    st("trig_latency", 1, 0, 1, 2'd0, A_SEG);
    tick(); st("ring_tick1", 1, 0, 0, 2'd0, BLANK);
    tick(); st("ring_tick2", 1, 0, 1, 2'd0, A_SEG);
    tick(); st("ring_tick3", 1, 0, 0, 2'd0, BLANK);
    tick(); st("ring_timeout", 0, 0, 0, 2'd0, BLANK);
    quiet(5);
    st("no_retrig_level_high", 0, 0, 0, 2'd0, BLANK);

    // Snooze, re-ring, snooze limit
    new_trigger();
    st("ring2_start", 1, 0, 1, 2'd0, A_SEG);
    pulse_snooze();
    st("snooze1", 0, 1, 0, 2'd1, S_SEG);
    tick(); tick();
    st("snooze_tick2", 0, 1, 0, 2'd1, S_SEG);
    tick();
    st("rering1", 1, 0, 1, 2'd1, A_SEG);
    tick();
    st("rering1_tick1", 1, 0, 0, 2'd1, BLANK);
    pulse_snooze();
    st("snooze2", 0, 1, 0, 2'd2, S_SEG);
    pulse_snooze();
    st("snooze_btn_ignored_in_snooze", 0, 1, 0, 2'd2, S_SEG);
    tick(); tick(); tick();
    st("rering2", 1, 0, 1, 2'd2, A_SEG);
    pulse_snooze();
    st("snooze_limit", 1, 0, 1, 2'd2, A_SEG);
    tick(); tick(); tick();
    st("rering2_tick3", 1, 0, 0, 2'd2, BLANK);
    tick();
    st("rering2_timeout_count_held", 0, 0, 0, 2'd2, BLANK);

    // Stop with trigger still high
    new_trigger();
    st("ring3_count_cleared", 1, 0, 1, 2'd0, A_SEG);
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
    st("stop", 0, 0, 0, 2'd0, BLANK);
    quiet(5);
    st("stop_no_retrig", 0, 0, 0, 2'd0, BLANK);
    new_trigger();
    st("retrig_after_fall", 1, 0, 1, 2'd0, A_SEG);

    // Stop + snooze together: stop wins, count unchanged
    pulse_snooze();
    tick(); tick(); tick();
    st("rering_before_both", 1, 0, 1, 2'd1, A_SEG);
    stop_btn = 1'b1; snooze_btn = 1'b1; step();
    stop_btn = 1'b0; snooze_btn = 1'b0;
    st("stop_and_snooze", 0, 0, 0, 2'd1, BLANK);

    // Snooze together with the terminal tick: snooze wins
    new_trigger();
    tick(); tick(); tick();
    quiet(9);
    sec_tick = 1'b1; snooze_btn = 1'b1; step();
    sec_tick = 1'b0; snooze_btn = 1'b0;
    st("snooze_beats_timeout", 0, 1, 0, 2'd1, S_SEG);
    alarm_enable = 1'b0; step();
    st("disable_in_snooze", 0, 0, 0, 2'd1, BLANK);

    // Disabled alarm ignores a trigger rise
    new_trigger();
    st("disabled_no_ring", 0, 0, 0, 2'd1, BLANK);
    alarm_enable = 1'b1;
    quiet(3);
    st("enable_with_level_high", 0, 0, 0, 2'd1, BLANK);

    // Asynchronous reset mid-snooze, released with trigger high
    new_trigger();
    pulse_snooze();
    st("pre_reset_snooze", 0, 1, 0, 2'd1, S_SEG);
    #2 rst = 1'b1;
    #1;
    st("async_reset", 0, 0, 0, 2'd0, BLANK);
    quiet(2);
    rst = 1'b0;
    quiet(5);
    st("reset_release_trig_high", 0, 0, 0, 2'd0, BLANK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
